stack_arbiter: RTL and testbench

Shares one instance of the team's LIFO stack (push/pop/init, registered `dout`, `empty` flag, no full flag) between two requesters, e.g. a path recorder and a path replayer. It does three things: round-robin arbitration, sequencing each push/pop with a request/acknowledge handshake, and tracking occupancy so overflow and underflow are rejected before they reach the stack. It sits between the clients and the stack ports, and is the only driver of the stack's `push`, `pop`, `init` and `din`.

---
 rtl/stack_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_stack_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - round-robin arbiter and push/pop handshake sequencer for a shared LIFO stack
// Optional feature macro: STACK_ARB_STATUS_EN (adds level/full outputs and the occupancy consistency check)
module stack_arbiter #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 256
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             req0,
    input  logic             req1,
    input  logic             op0,
    input  logic             op1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] rdata,
    output logic             stk_init,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_din,
    input  logic [WIDTH-1:0] stk_dout,
    input  logic             stk_empty
`ifdef STACK_ARB_STATUS_EN
    ,
    output logic [$clog2(DEPTH)-1:0] level,
    output logic                     full
`endif
);

    localparam int CW = $clog2(DEPTH);
    // One slot is held back so the stack index never wraps back to zero.
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             gnt_q, gnt_d;
    logic             gop_q, gop_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             err0_q, err0_d;
    logic             err1_q, err1_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             stk_init_q, stk_init_d;
    logic             stk_push_q, stk_push_d;
    logic             stk_pop_q, stk_pop_d;
    logic [WIDTH-1:0] stk_din_q, stk_din_d;

    // Arbitration helpers: a client still seeing its own ack is not eligible.
    logic             elig0, elig1, any_elig;
    logic             sel;
    logic             sel_op;
    logic [WIDTH-1:0] sel_wdata;

    // Completion event for this cycle: which client, and whether it was rejected.
    logic             done;
    logic             done_err;
    logic             done_client;

    // Pick the winner among eligible clients; on a tie the client not granted last time wins.
    always_comb begin
        elig0     = req0 & ~ack0_q;
        elig1     = req1 & ~ack1_q;
        any_elig  = elig0 | elig1;
        sel       = (elig0 & elig1) ? ~last_q : elig1;
        sel_op    = sel ? op1 : op0;
        sel_wdata = sel ? wdata1 : wdata0;
    end

    // Next-state, occupancy tracking and registered command/response generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        gop_d       = gop_q;
        rdata_d     = '0;
        stk_init_d  = 1'b0;
        stk_push_d  = 1'b0;
        stk_pop_d   = 1'b0;
        stk_din_d   = stk_din_q;
        done        = 1'b0;
        done_err    = 1'b0;
        done_client = gnt_q;

        if (clr) begin
            // Clear wins over everything; an operation already granted is closed out as an error.
            stk_init_d = 1'b1;
            cnt_d      = '0;
            last_d     = 1'b1;
            state_d    = IDLE;
            if (state_q != IDLE) begin
                done        = 1'b1;
                done_err    = 1'b1;
                done_client = gnt_q;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_elig) begin
                        last_d = sel;
                        gnt_d  = sel;
                        gop_d  = sel_op;
                        if (!sel_op) begin
                            if (cnt_q == CNT_MAX) begin
                                done        = 1'b1;
                                done_err    = 1'b1;
                                done_client = sel;
                            end else begin
                                stk_push_d = 1'b1;
                                stk_din_d  = sel_wdata;
                                cnt_d      = cnt_q + 1'b1;
                                state_d    = ISSUE;
                            end
                        end else begin
                            if (cnt_q == '0) begin
                                done        = 1'b1;
                                done_err    = 1'b1;
                                done_client = sel;
                            end else begin
                                stk_pop_d = 1'b1;
                                cnt_d     = cnt_q - 1'b1;
                                state_d   = ISSUE;
                            end
                        end
                    end
                end
                ISSUE: begin
                    // Stack performs the operation on this edge; dout is valid afterwards.
                    state_d = RESP;
                end
                RESP: begin
                    done        = 1'b1;
                    done_err    = 1'b0;
                    done_client = gnt_q;
                    if (gop_q) begin
                        rdata_d = stk_dout;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        ack0_d = done & ~done_client;
        ack1_d = done & done_client;
        err0_d = ack0_d & done_err;
        err1_d = ack1_d & done_err;
    end

    // State and output registers; reset clears any in-flight operation without acknowledging it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            gop_q      <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata_q    <= '0;
            stk_init_q <= 1'b0;
            stk_push_q <= 1'b0;
            stk_pop_q  <= 1'b0;
            stk_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            gop_q      <= gop_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rdata_q    <= rdata_d;
            stk_init_q <= stk_init_d;
            stk_push_q <= stk_push_d;
            stk_pop_q  <= stk_pop_d;
            stk_din_q  <= stk_din_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign err0     = err0_q;
    assign err1     = err1_q;
    assign rdata    = rdata_q;
    assign stk_init = stk_init_q;
    assign stk_push = stk_push_q;
    assign stk_pop  = stk_pop_q;
    assign stk_din  = stk_din_q;

`ifdef STACK_ARB_STATUS_EN
    logic [CW-1:0] level_q;
    logic          full_q;

    // Registered occupancy status, tracking cnt.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            level_q <= '0;
            full_q  <= 1'b0;
        end else begin
            level_q <= cnt_d;
            full_q  <= (cnt_d == CNT_MAX);
        end
    end

    assign level = level_q;
    assign full  = full_q;

    // The stack's own empty flag must agree with the occupancy counter once a clear has settled.
    always @(posedge CLK) begin
        if (RST_N && (state_q == IDLE) && !stk_init_q) begin
            assert (stk_empty == (cnt_q == '0));
        end
    end
`else
    logic unused_stk_empty;
    assign unused_stk_empty = stk_empty;
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - scoreboard bench for stack_arbiter with behavioural LIFO models
module tb_stack_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST_N;

    // Main instance, DEPTH=256
    logic       clr, req0, req1, op0, op1;
    logic [1:0] wdata0, wdata1;
    logic       ack0, ack1, err0, err1;
    logic [1:0] rdata;
    logic       stk_init, stk_push, stk_pop;
    logic [1:0] stk_din, stk_dout;
    logic       stk_empty;
`ifdef STACK_ARB_STATUS_EN
    logic [7:0] level;
    logic       full;
`endif

    // Small instance, DEPTH=4
    logic       clr_b, req0_b, req1_b, op0_b, op1_b;
    logic [1:0] wdata0_b, wdata1_b;
    logic       ack0_b, ack1_b, err0_b, err1_b;
    logic [1:0] rdata_b;
    logic       stk_init_b, stk_push_b, stk_pop_b;
    logic [1:0] stk_din_b, stk_dout_b;
    logic       stk_empty_b;
`ifdef STACK_ARB_STATUS_EN
    logic [1:0] level_b;
    logic       full_b;
`endif

    stack_arbiter #(.WIDTH(2), .DEPTH(256)) dut (
        .CLK(CLK), .RST_N(RST_N), .clr(clr),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
        .stk_init(stk_init), .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .stk_empty(stk_empty)
`ifdef STACK_ARB_STATUS_EN
        , .level(level), .full(full)
`endif
    );

    stack_arbiter #(.WIDTH(2), .DEPTH(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .clr(clr_b),
        .req0(req0_b), .req1(req1_b), .op0(op0_b), .op1(op1_b),
        .wdata0(wdata0_b), .wdata1(wdata1_b),
        .ack0(ack0_b), .ack1(ack1_b), .err0(err0_b), .err1(err1_b), .rdata(rdata_b),
        .stk_init(stk_init_b), .stk_push(stk_push_b), .stk_pop(stk_pop_b), .stk_din(stk_din_b),
        .stk_dout(stk_dout_b), .stk_empty(stk_empty_b)
`ifdef STACK_ARB_STATUS_EN
        , .level(level_b), .full(full_b)
`endif
    );

    // Behavioural LIFO models with registered dout
    logic [1:0] mem_a [0:1023];
    logic [9:0] sp_a;
    logic [1:0] mem_b [0:1023];
    logic [9:0] sp_b;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sp_a <= '0; stk_dout <= '0;
        end else if (stk_init) begin
            sp_a <= '0; stk_dout <= '0;
        end else if (stk_push) begin
            mem_a[sp_a] <= stk_din; sp_a <= sp_a + 1'b1;
        end else if (stk_pop) begin
            stk_dout <= mem_a[sp_a - 1'b1]; sp_a <= sp_a - 1'b1;
        end
    end
    assign stk_empty = (sp_a == '0);

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sp_b <= '0; stk_dout_b <= '0;
        end else if (stk_init_b) begin
            sp_b <= '0; stk_dout_b <= '0;
        end else if (stk_push_b) begin
            mem_b[sp_b] <= stk_din_b; sp_b <= sp_b + 1'b1;
        end else if (stk_pop_b) begin
            stk_dout_b <= mem_b[sp_b - 1'b1]; sp_b <= sp_b - 1'b1;
        end
    end
    assign stk_empty_b = (sp_b == '0);

    int errors = 0;
    int checks = 0;

    // Command pulse counters, sampled just before each edge
    int n_push = 0, n_pop = 0, n_init = 0, n_push_b = 0;
    always @(posedge CLK) begin
        if (stk_push)   n_push++;
        if (stk_pop)    n_pop++;
        if (stk_init)   n_init++;
        if (stk_push_b) n_push_b++;
    end

    // Scoreboard entry: client, err, compare-rdata flag, rdata
    typedef struct packed {
        logic       c;
        logic       e;
        logic       chk;
        logic [1:0] d;
    } exp_t;
    exp_t sb[$];

    // Every ack on the main instance is matched against the next expected completion
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && (ack0 || ack1)) begin
            exp_t w;
            logic ge;
            ge = ack1 ? err1 : err0;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ack: got ack0=%0b ack1=%0b with no completion expected", ack0, ack1);
            end else begin
                w = sb.pop_front();
                if ((ack0 && ack1) || (ack1 !== w.c) || (ge !== w.e) ||
                    (ack1 ? err0 : err1) !== 1'b0 || (w.chk && rdata !== w.d)) begin
                    errors++;
                    $display("FAIL sb_ack: got client=%0d(ack0=%0b ack1=%0b) err=%0b rdata=%b, want client=%0d err=%0b rdata=%b",
                             ack1, ack0, ack1, ge, rdata, w.c, w.e, w.d);
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        clr = 0; req0 = 0; req1 = 0; op0 = 0; op1 = 0; wdata0 = 0; wdata1 = 0;
        clr_b = 0; req0_b = 0; req1_b = 0; op0_b = 0; op1_b = 0; wdata0_b = 0; wdata1_b = 0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    // Drive one operation and return latency (negedges until ack) plus the err/rdata seen with ack
    task automatic issue(input bit dev, input bit c, input logic o, input logic [1:0] wd,
                         output int lat, output logic e, output logic [1:0] d);
        logic a;
        lat = 0; e = 1'bx; d = 2'bxx;
        if (dev) begin req0_b = 1; op0_b = o; wdata0_b = wd; end
        else if (c) begin req1 = 1; op1 = o; wdata1 = wd; end
        else begin req0 = 1; op0 = o; wdata0 = wd; end
        do begin
            @(negedge CLK);
            lat++;
            a = dev ? ack0_b : (c ? ack1 : ack0);
        end while (!a && lat < 20);
        if (a) begin
            e = dev ? err0_b : (c ? err1 : err0);
            d = dev ? rdata_b : rdata;
        end
        if (dev) req0_b = 0; else if (c) req1 = 0; else req0 = 0;
        @(negedge CLK);
    endtask

    // Both clients request the same kind of op; client 0 sends 01, client 1 sends 11
    task automatic drive_pair(input logic o, input int per, output logic [3:0] ord, output int n);
        int a0 = 0;
        int a1 = 0;
        int cyc = 0;
        n = 0; ord = '0;
        req0 = 1; req1 = 1; op0 = o; op1 = o; wdata0 = 2'b01; wdata1 = 2'b11;
        while ((a0 < per || a1 < per) && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            if (ack0 && n < 4) begin ord[n] = 1'b0; n++; a0++; if (a0 == per) req0 = 0; end
            if (ack1 && n < 4) begin ord[n] = 1'b1; n++; a1++; if (a1 == per) req1 = 0; end
        end
        req0 = 0; req1 = 0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({ack0, ack1, err0, err1, rdata, stk_init, stk_push, stk_pop, stk_din} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want all zero", {ack0, ack1, err0, err1, rdata, stk_init, stk_push, stk_pop, stk_din});
        end
        checks++;
        if ({ack0_b, ack1_b, err0_b, err1_b, rdata_b, stk_init_b, stk_push_b, stk_pop_b, stk_din_b} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs_d4: got %b want all zero", {ack0_b, ack1_b, err0_b, err1_b, rdata_b, stk_init_b, stk_push_b, stk_pop_b, stk_din_b});
        end
`ifdef STACK_ARB_STATUS_EN
        checks++;
        if (level !== 8'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got level=%0d full=%0b want 0 0", level, full);
        end
`endif
    endtask

    task automatic test_push_pop();
        int lat; logic e; logic [1:0] d; int p;
        sb.push_back('{c: 1'b0, e: 1'b0, chk: 1'b0, d: 2'b00});
        issue(0, 0, 0, 2'b10, lat, e, d);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL push_latency: got %0d want 3", lat); end
        sb.push_back('{c: 1'b0, e: 1'b0, chk: 1'b1, d: 2'b10});
        issue(0, 0, 1, 2'b00, lat, e, d);
        checks++;
        if (lat !== 3 || d !== 2'b10) begin errors++; $display("FAIL pop_result: got lat=%0d rdata=%b want 3 10", lat, d); end
        // Occupancy is back to zero, so another pop is rejected without touching the stack
        p = n_pop;
        sb.push_back('{c: 1'b0, e: 1'b1, chk: 1'b1, d: 2'b00});
        issue(0, 0, 1, 2'b00, lat, e, d);
        checks++;
        if (lat !== 1 || e !== 1'b1 || n_pop !== p) begin
            errors++;
            $display("FAIL pop_after_drain: got lat=%0d err=%0b pops=%0d want 1 1 %0d", lat, e, n_pop, p);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] ord; int n;
        apply_reset();
        for (int i = 0; i < 4; i++) sb.push_back('{c: i[0], e: 1'b0, chk: 1'b0, d: 2'b00});
        drive_pair(1'b0, 2, ord, n);
        checks++;
        if (n !== 4 || ord !== 4'b1010) begin errors++; $display("FAIL rr_push_order: got n=%0d order=%b want 4 1010", n, ord); end
        sb.push_back('{c: 1'b0, e: 1'b0, chk: 1'b1, d: 2'b11});
        sb.push_back('{c: 1'b1, e: 1'b0, chk: 1'b1, d: 2'b01});
        sb.push_back('{c: 1'b0, e: 1'b0, chk: 1'b1, d: 2'b11});
        sb.push_back('{c: 1'b1, e: 1'b0, chk: 1'b1, d: 2'b01});
        drive_pair(1'b1, 2, ord, n);
        checks++;
        if (n !== 4 || ord !== 4'b1010) begin errors++; $display("FAIL rr_pop_order: got n=%0d order=%b want 4 1010", n, ord); end
    endtask

    task automatic test_full();
        int lat; logic e; logic [1:0] d; int pb;
        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            logic [1:0] v;
            v = i[1:0];
            issue(1, 0, 0, v, lat, e, d);
            checks++;
            if (lat !== 3 || e !== 1'b0) begin errors++; $display("FAIL full_fill_%0d: got lat=%0d err=%0b want 3 0", i, lat, e); end
        end
`ifdef STACK_ARB_STATUS_EN
        checks++;
        if (full_b !== 1'b1 || level_b !== 2'd3) begin errors++; $display("FAIL full_flag: got full=%0b level=%0d want 1 3", full_b, level_b); end
`endif
        pb = n_push_b;
        issue(1, 0, 0, 2'b00, lat, e, d);
        checks++;
        if (lat !== 1 || e !== 1'b1 || d !== 2'b00 || n_push_b !== pb) begin
            errors++;
            $display("FAIL full_reject: got lat=%0d err=%0b rdata=%b pushes=%0d want 1 1 00 %0d", lat, e, d, n_push_b, pb);
        end
        issue(1, 0, 1, 2'b00, lat, e, d);
        checks++;
        if (lat !== 3 || e !== 1'b0 || d !== 2'b11) begin errors++; $display("FAIL full_pop_top: got lat=%0d err=%0b rdata=%b want 3 0 11", lat, e, d); end
    endtask

    task automatic test_pop_empty();
        int lat; logic e; logic [1:0] d; int p;
        apply_reset();
        p = n_pop;
        sb.push_back('{c: 1'b1, e: 1'b1, chk: 1'b1, d: 2'b00});
        issue(0, 1, 1, 2'b00, lat, e, d);
        checks++;
        if (lat !== 1 || e !== 1'b1 || d !== 2'b00 || n_pop !== p) begin
            errors++;
            $display("FAIL pop_empty: got lat=%0d err=%0b rdata=%b pops=%0d want 1 1 00 %0d", lat, e, d, n_pop, p);
        end
    endtask

    task automatic test_clr_issue();
        int lat; logic e; logic [1:0] d; int pi;
        pi = n_init;
        sb.push_back('{c: 1'b0, e: 1'b1, chk: 1'b0, d: 2'b00});
        req0 = 1; op0 = 0; wdata0 = 2'b11;
        @(negedge CLK);
        checks++;
        if (stk_push !== 1'b1) begin errors++; $display("FAIL clr_push_issued: got stk_push=%0b want 1", stk_push); end
        clr = 1;
        @(negedge CLK);
        checks++;
        if (ack0 !== 1'b1 || err0 !== 1'b1 || stk_init !== 1'b1) begin
            errors++;
            $display("FAIL clr_abort: got ack0=%0b err0=%0b stk_init=%0b want 1 1 1", ack0, err0, stk_init);
        end
        clr = 0; req0 = 0;
        @(negedge CLK);
        checks++;
        if (n_init !== pi + 1) begin errors++; $display("FAIL clr_init_pulses: got %0d want %0d", n_init, pi + 1); end
        sb.push_back('{c: 1'b0, e: 1'b1, chk: 1'b1, d: 2'b00});
        issue(0, 0, 1, 2'b00, lat, e, d);
        checks++;
        if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL clr_then_pop: got lat=%0d err=%0b want 1 1", lat, e); end
    endtask

    task automatic test_reset_mid();
        int a = 0;
        logic [3:0] ord; int n;
        req0 = 1; op0 = 0; wdata0 = 2'b01;
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        checks++;
        if ({ack0, ack1, err0, err1, rdata, stk_init, stk_push, stk_pop, stk_din} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b want all zero", {ack0, ack1, err0, err1, rdata, stk_init, stk_push, stk_pop, stk_din});
        end
        @(negedge CLK);
        RST_N = 1'b1; req0 = 0;
        repeat (6) begin
            @(negedge CLK);
            if (ack0 || ack1) a++;
        end
        checks++;
        if (a !== 0) begin errors++; $display("FAIL reset_mid_no_ack: got %0d acks want 0", a); end
        sb.push_back('{c: 1'b0, e: 1'b0, chk: 1'b0, d: 2'b00});
        sb.push_back('{c: 1'b1, e: 1'b0, chk: 1'b0, d: 2'b00});
        drive_pair(1'b0, 1, ord, n);
        checks++;
        if (n !== 2 || ord[1:0] !== 2'b10) begin errors++; $display("FAIL reset_mid_tie: got n=%0d order=%b want 2 10", n, ord[1:0]); end
    endtask

    initial begin
        RST_N = 1'b0;
        clr = 0; req0 = 0; req1 = 0; op0 = 0; op1 = 0; wdata0 = 0; wdata1 = 0;
        clr_b = 0; req0_b = 0; req1_b = 0; op0_b = 0; op1_b = 0; wdata0_b = 0; wdata1_b = 0;
        test_reset();
        test_push_pop();
        test_round_robin();
        test_full();
        test_pop_empty();
        test_clr_issue();
        test_reset_mid();
        repeat (2) @(negedge CLK);
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL sb_drained: got %0d pending want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
